// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - up/down modulo counter with step, wrap/saturate, clear, load and wrap flags
// Bound detection runs in BITS+1 bits so value+STEP never truncates before the compare.
module updown_counter #(
  parameter int LIMIT         = 1000,
  parameter int START_FROM    = 0,
  parameter int CONTINUE_FROM = START_FROM,
  parameter int STEP          = 1,
  parameter bit SATURATE      = 1'b0,
  localparam int BITS         = $clog2(LIMIT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            clr,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] value,
  output logic            will_overflow,
  output logic            will_underflow,
  output logic            wrapped,
  output logic            sticky_wrap
);

  localparam logic [BITS:0]   C_LIMIT  = (BITS+1)'(LIMIT);
  localparam logic [BITS:0]   C_STEP_W = (BITS+1)'(STEP);
  localparam logic [BITS-1:0] C_STEP   = BITS'(STEP);
  localparam logic [BITS-1:0] C_MAX    = BITS'(LIMIT - 1);
  localparam logic [BITS-1:0] C_START  = BITS'(START_FROM);
  localparam logic [BITS-1:0] C_CONT   = BITS'(CONTINUE_FROM);

  logic [BITS-1:0] r_value;
  logic            r_wrapped;
  logic            r_sticky;

  logic [BITS:0]   w_sum;
  logic            w_up_hit;
  logic            w_dn_hit;
  logic            w_hit;
  logic [BITS-1:0] w_next_up;
  logic [BITS-1:0] w_next_dn;
  logic [BITS-1:0] w_load_clamped;

  assign w_sum    = {1'b0, r_value} + C_STEP_W;
  assign w_up_hit = (w_sum >= C_LIMIT);
  assign w_dn_hit = (r_value < C_STEP);
  assign w_hit    = up ? w_up_hit : w_dn_hit;

  // An up-wrap always lands on CONTINUE_FROM; the overshoot is deliberately discarded.
  assign w_next_up = w_up_hit ? (SATURATE ? C_MAX : C_CONT) : w_sum[BITS-1:0];
  assign w_next_dn = w_dn_hit ? (SATURATE ? '0 : C_MAX) : (r_value - C_STEP);

  assign w_load_clamped = ({1'b0, load_value} >= C_LIMIT) ? C_MAX : load_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value   <= C_START;
      r_wrapped <= 1'b0;
      r_sticky  <= 1'b0;
    end else if (clr) begin
      r_value   <= C_START;
      r_wrapped <= 1'b0;
      r_sticky  <= 1'b0;
    end else if (load) begin
      r_value   <= w_load_clamped;
      r_wrapped <= 1'b0;
    end else if (en) begin
      r_value   <= up ? w_next_up : w_next_dn;
      r_wrapped <= w_hit;
      if (w_hit) begin
        r_sticky <= 1'b1;
      end
    end else begin
      r_wrapped <= 1'b0;
    end
  end

  assign value          = r_value;
  assign wrapped        = r_wrapped;
  assign sticky_wrap    = r_sticky;
  assign will_overflow  = en & up & w_up_hit;
  assign will_underflow = en & ~up & w_dn_hit;

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - directed scoreboard bench over six counter configurations
module tb_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  localparam int N = 6;
  logic       s_en   [N];
  logic       s_up   [N];
  logic       s_clr  [N];
  logic       s_load [N];
  logic [9:0] s_lv   [N];

  logic [9:0] val_a;
  logic [3:0] val_b, val_c, val_d, val_e;
  logic [2:0] val_f;
  logic [N-1:0] wo, wu, wr, st;

  // 0: defaults, 1: L10 S3 wrap, 2: L10 S3 sat, 3: L10 S1 wrap, 4: L10 S1 sat, 5: L8 start2 cont5
  updown_counter u_a (.clk(clk), .rst(rst), .en(s_en[0]), .up(s_up[0]), .clr(s_clr[0]), .load(s_load[0]),
    .load_value(s_lv[0]), .value(val_a), .will_overflow(wo[0]), .will_underflow(wu[0]), .wrapped(wr[0]), .sticky_wrap(st[0]));
  updown_counter #(.LIMIT(10), .STEP(3)) u_b (.clk(clk), .rst(rst), .en(s_en[1]), .up(s_up[1]), .clr(s_clr[1]), .load(s_load[1]),
    .load_value(s_lv[1][3:0]), .value(val_b), .will_overflow(wo[1]), .will_underflow(wu[1]), .wrapped(wr[1]), .sticky_wrap(st[1]));
  updown_counter #(.LIMIT(10), .STEP(3), .SATURATE(1'b1)) u_c (.clk(clk), .rst(rst), .en(s_en[2]), .up(s_up[2]), .clr(s_clr[2]), .load(s_load[2]),
    .load_value(s_lv[2][3:0]), .value(val_c), .will_overflow(wo[2]), .will_underflow(wu[2]), .wrapped(wr[2]), .sticky_wrap(st[2]));
  updown_counter #(.LIMIT(10)) u_d (.clk(clk), .rst(rst), .en(s_en[3]), .up(s_up[3]), .clr(s_clr[3]), .load(s_load[3]),
    .load_value(s_lv[3][3:0]), .value(val_d), .will_overflow(wo[3]), .will_underflow(wu[3]), .wrapped(wr[3]), .sticky_wrap(st[3]));
  updown_counter #(.LIMIT(10), .SATURATE(1'b1)) u_e (.clk(clk), .rst(rst), .en(s_en[4]), .up(s_up[4]), .clr(s_clr[4]), .load(s_load[4]),
    .load_value(s_lv[4][3:0]), .value(val_e), .will_overflow(wo[4]), .will_underflow(wu[4]), .wrapped(wr[4]), .sticky_wrap(st[4]));
  updown_counter #(.LIMIT(8), .START_FROM(2), .CONTINUE_FROM(5)) u_f (.clk(clk), .rst(rst), .en(s_en[5]), .up(s_up[5]), .clr(s_clr[5]), .load(s_load[5]),
    .load_value(s_lv[5][2:0]), .value(val_f), .will_overflow(wo[5]), .will_underflow(wu[5]), .wrapped(wr[5]), .sticky_wrap(st[5]));

  typedef struct {
    int id;
    int v;
    bit w;
    bit s;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int get_val(int id);
    case (id)
      0: return int'(val_a);
      1: return int'(val_b);
      2: return int'(val_c);
      3: return int'(val_d);
      4: return int'(val_e);
      default: return int'(val_f);
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      s_en[i] = 1'b0; s_up[i] = 1'b0; s_clr[i] = 1'b0; s_load[i] = 1'b0; s_lv[i] = '0;
    end
  endtask

  // Drive one cycle on instance id, check will_* before the edge, then score value/wrapped/sticky after it.
  task automatic step(string tag, int id, bit e, bit u, bit c, bit l, int lv,
                      bit ewo, bit ewu, int ev, bit ew, bit es);
    exp_t x;
    @(negedge clk);
    idle();
    s_en[id] = e; s_up[id] = u; s_clr[id] = c; s_load[id] = l; s_lv[id] = 10'(lv);
    sb.push_back('{id: id, v: ev, w: ew, s: es});
    #1;
    chk({tag, ".will_overflow"},  int'(wo[id]), int'(ewo));
    chk({tag, ".will_underflow"}, int'(wu[id]), int'(ewu));
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".value"},   get_val(x.id),   x.v);
    chk({tag, ".wrapped"}, int'(wr[x.id]),  int'(x.w));
    chk({tag, ".sticky"},  int'(st[x.id]),  int'(x.s));
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.a_value", get_val(0), 0);
    chk("reset.f_value", get_val(5), 2);
    chk("reset.wrapped", int'(wr), 0);
    chk("reset.sticky",  int'(st), 0);
    @(negedge clk);
    rst = 1'b1;

    // Defaults: full cycle 0..999 then 0, one wrap pulse at 999->0
    for (int k = 0; k < 1000; k++) begin
      step("t1.count", 0, 1, 1, 0, 0, 0, k == 999, 0, (k + 1) % 1000, k == 999, k == 999);
    end
    step("t1.after", 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1);

    // LIMIT=10 STEP=3, wrap then saturate
    step("t2w.0", 1, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0);
    step("t2w.1", 1, 1, 1, 0, 0, 0, 0, 0, 6, 0, 0);
    step("t2w.2", 1, 1, 1, 0, 0, 0, 0, 0, 9, 0, 0);
    step("t2w.3", 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1);
    step("t2s.0", 2, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0);
    step("t2s.1", 2, 1, 1, 0, 0, 0, 0, 0, 6, 0, 0);
    step("t2s.2", 2, 1, 1, 0, 0, 0, 0, 0, 9, 0, 0);
    step("t2s.3", 2, 1, 1, 0, 0, 0, 1, 0, 9, 1, 1);
    step("t2s.4", 2, 1, 1, 0, 0, 0, 1, 0, 9, 1, 1);

    // Down from 1, wrap then saturate
    step("t3w.load", 3, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    step("t3w.0",    3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t3w.1",    3, 1, 0, 0, 0, 0, 0, 1, 9, 1, 1);
    step("t3s.load", 4, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    step("t3s.0",    4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t3s.1",    4, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    step("t3s.2",    4, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1);

    // Load clamp, load beats en, clr beats load
    step("t4.clamp15", 3, 1, 1, 0, 1, 15, 1, 0, 9, 0, 1);
    step("t4.clamp10", 3, 0, 0, 0, 1, 10, 0, 0, 9, 0, 1);
    step("t4.load4",   3, 0, 0, 0, 1, 4,  0, 0, 4, 0, 1);
    step("t4.clrload", 3, 0, 0, 1, 1, 7,  0, 0, 0, 0, 0);

    // START_FROM=2, CONTINUE_FROM=5, LIMIT=8
    step("t5.0", 5, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0);
    step("t5.1", 5, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0);
    step("t5.2", 5, 1, 1, 0, 0, 0, 0, 0, 5, 0, 0);
    step("t5.3", 5, 1, 1, 0, 0, 0, 0, 0, 6, 0, 0);
    step("t5.4", 5, 1, 1, 0, 0, 0, 0, 0, 7, 0, 0);
    step("t5.5", 5, 1, 1, 0, 0, 0, 1, 0, 5, 1, 1);
    step("t5.6", 5, 1, 1, 0, 0, 0, 0, 0, 6, 0, 1);
    step("t5.hold", 5, 0, 1, 0, 0, 0, 0, 0, 6, 0, 1);
    step("t5.clr",  5, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);

    // Asynchronous reset mid-count, between edges
    step("t6.a0", 0, 1, 1, 0, 0, 0, 0, 0, 2, 0, 1);
    step("t6.a1", 0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 1);
    step("t6.c",  2, 1, 1, 0, 0, 0, 1, 0, 9, 1, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6.rst_a_value", get_val(0), 0);
    chk("t6.rst_c_value", get_val(2), 0);
    chk("t6.rst_d_value", get_val(3), 0);
    chk("t6.rst_f_value", get_val(5), 2);
    chk("t6.rst_wrapped", int'(wr), 0);
    chk("t6.rst_sticky",  int'(st), 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("t6.rst_hold_a", get_val(0), 0);
    @(negedge clk);
    rst = 1'b1;
    step("t6.resume_a", 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    step("t6.resume_f", 5, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
